// File: rtl/uart_rx_deframer_if.sv
// Parallel result port of the UART receive deframer.
// data_valid is a one-cycle strobe with no ready: the consumer must take data_out/parity_err/frame_err in that cycle.
interface uart_rx_deframer_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output data_out,
      output data_valid,
      output parity_err,
      output frame_err,
      output busy
   );

   modport slave (
      input data_out,
      input data_valid,
      input parity_err,
      input frame_err,
      input busy
   );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start, DATA_BITS LSB-first, parity, stop, timed by an oversample tick.
// Define RX_MAJORITY_EN to take each bit as a 2-of-3 vote over the last three ticks.
module uart_rx_deframer #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic               baud_clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               rx_in,
   uart_rx_deframer_if.master rx_if,
   output logic [2:0]         state_dbg
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] TC_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] TC_FULL = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);
   localparam logic          PAR_ODD = 1'(PARITY_ODD);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t               state;
   logic                 rx_m;
   logic                 rx_s;
   logic [CW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 perr;
   logic                 samp;

   assign state_dbg = state;

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
      end
   end

`ifdef RX_MAJORITY_EN
   // History of the two previous ticks; with the current rx_s this spans N-2..N.
   logic [1:0] vote_h;

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         vote_h <= 2'b11;
      end else if (tick) begin
         vote_h <= {vote_h[0], rx_s};
      end
   end

   assign samp = (vote_h[1] & vote_h[0]) | (vote_h[1] & rx_s) | (vote_h[0] & rx_s);
`else
   assign samp = rx_s;
`endif

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         state            <= S_IDLE;
         tick_cnt         <= '0;
         bit_cnt          <= '0;
         shift_reg        <= '0;
         perr             <= 1'b0;
         rx_if.data_out   <= '0;
         rx_if.data_valid <= 1'b0;
         rx_if.parity_err <= 1'b0;
         rx_if.frame_err  <= 1'b0;
         rx_if.busy       <= 1'b0;
      end else begin
         rx_if.data_valid <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (!rx_s) begin
                     state      <= S_START;
                     tick_cnt   <= '0;
                     rx_if.busy <= 1'b1;
                  end
               end
               S_START: begin
                  if (tick_cnt == TC_HALF) begin
                     tick_cnt <= '0;
                     if (!samp) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                     end else begin
                        state      <= S_IDLE;
                        rx_if.busy <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (tick_cnt == TC_FULL) begin
                     tick_cnt  <= '0;
                     shift_reg <= {samp, shift_reg[DATA_BITS-1:1]};
                     if (bit_cnt == BC_LAST) begin
                        bit_cnt <= '0;
                        state   <= S_PARITY;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               S_PARITY: begin
                  if (tick_cnt == TC_FULL) begin
                     tick_cnt <= '0;
                     perr     <= (^shift_reg) ^ samp ^ PAR_ODD;
                     state    <= S_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               S_STOP: begin
                  if (tick_cnt == TC_FULL) begin
                     tick_cnt         <= '0;
                     rx_if.data_out   <= shift_reg;
                     rx_if.parity_err <= perr;
                     rx_if.frame_err  <= ~samp;
                     rx_if.data_valid <= 1'b1;
                     if (samp) begin
                        state      <= S_IDLE;
                        rx_if.busy <= 1'b0;
                     end else begin
                        state <= S_BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               // A line held low after a bad stop must rise before a new start counts.
               S_BREAK: begin
                  if (rx_s) begin
                     state      <= S_IDLE;
                     rx_if.busy <= 1'b0;
                  end
               end
               default: begin
                  state      <= S_IDLE;
                  rx_if.busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
